// File: rtl/systolic_drain_if.sv
// Result stream from the systolic drain to the activation writeback path.
// A beat transfers on any rising clock edge where out_valid and out_ready are both high.
// The master holds out_data, out_idx and out_last stable while out_valid & ~out_ready.
// out_valid never drops without a transfer.
interface systolic_drain_if #(
  parameter int IDX_W = 2
);
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;

  modport master (output out_valid, out_data, out_idx, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_idx, out_last, output out_ready);
endinterface

// File: rtl/systolic_drain.sv
// Captures the N*N PE accumulators/exponents on a done rise and streams them as FP16.
// Each element passes through CONVERT (a one-cycle bubble) and then SEND.
module systolic_drain #(
  parameter int ACC_WIDTH = 32,
  parameter int N         = 2,
  parameter int IDX_W     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     done,
  input  logic [N*N*ACC_WIDTH-1:0] acc_in,
  input  logic [N*N*5-1:0]         exp_in,
  systolic_drain_if.master         out_bus,
  output logic                     busy,
  output logic                     overrun,
  output logic [1:0]               dbg_state
);
  localparam int NUM = N * N;

  typedef enum logic [1:0] {IDLE = 2'd0, CONVERT = 2'd1, SEND = 2'd2} state_t;

  state_t                 state_q;
  logic                   done_q;
  logic [ACC_WIDTH-1:0]   acc_q [NUM];
  logic [4:0]             exp_q [NUM];
  logic [IDX_W-1:0]       k_q;
  logic                   out_valid_q;
  logic [15:0]            out_data_q;
  logic [IDX_W-1:0]       out_idx_q;
  logic                   out_last_q;
  logic                   busy_q;
  logic                   overrun_q;
  logic                   rise;
  logic [15:0]            conv_d;

  // value = signed(acc) * 2^(exp-25); mantissa truncated, no denormals
  function automatic logic [15:0] to_fp16(input logic [ACC_WIDTH-1:0] acc, input logic [4:0] ex);
    logic                 s;
    logic [ACC_WIDTH-1:0] mag;
    logic [ACC_WIDTH-1:0] norm;
    logic [9:0]           mant;
    int                   p;
    int                   e;
    s    = acc[ACC_WIDTH-1];
    mag  = s ? (~acc + 1'b1) : acc;
    p    = 0;
    for (int i = 0; i < ACC_WIDTH; i++) begin
      if (mag[i]) p = i;
    end
    norm = mag << (ACC_WIDTH - 1 - p);
    mant = norm[ACC_WIDTH-2 -: 10];
    e    = p + int'(ex) - 10;
    if (mag == '0)   return 16'h0000;
    else if (e >= 31) return {s, 5'h1F, 10'h000};
    else if (e <= 0)  return {s, 15'h0000};
    else              return {s, e[4:0], mant};
  endfunction

  assign rise   = done & ~done_q;
  assign conv_d = to_fp16(acc_q[k_q], exp_q[k_q]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < NUM; i++) begin
        acc_q[i] <= '0;
        exp_q[i] <= '0;
      end
    end else begin
      done_q <= done;
      // busy is still high on the edge that accepts the last element
      if (rise && busy_q) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (rise) begin
            for (int i = 0; i < NUM; i++) begin
              acc_q[i] <= acc_in[i*ACC_WIDTH +: ACC_WIDTH];
              exp_q[i] <= exp_in[i*5 +: 5];
            end
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          out_data_q  <= conv_d;
          out_idx_q   <= k_q;
          out_last_q  <= (k_q == IDX_W'(NUM - 1));
          out_valid_q <= 1'b1;
          state_q     <= SEND;
        end
        SEND: begin
          if (out_valid_q && out_bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (out_last_q) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              k_q     <= k_q + 1'b1;
              state_q <= CONVERT;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_bus.out_valid = out_valid_q;
  assign out_bus.out_data  = out_data_q;
  assign out_bus.out_idx   = out_idx_q;
  assign out_bus.out_last  = out_last_q;
  assign busy              = busy_q;
  assign overrun           = overrun_q;
  assign dbg_state         = state_q;
endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain: expected FP16 beats are queued on stimulus,
// and a negedge monitor pops and compares each accepted beat.
module tb_systolic_drain;
  localparam int ACC_WIDTH = 32;
  localparam int N         = 2;
  localparam int IDX_W     = 2;

  logic                     clk;
  logic                     rst;
  logic                     done;
  logic [N*N*ACC_WIDTH-1:0] acc_in;
  logic [N*N*5-1:0]         exp_in;
  logic                     busy;
  logic                     overrun;
  logic [1:0]               dbg_state;

  systolic_drain_if #(.IDX_W(IDX_W)) bus ();

  systolic_drain #(.ACC_WIDTH(ACC_WIDTH), .N(N), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .done      (done),
    .acc_in    (acc_in),
    .exp_in    (exp_in),
    .out_bus   (bus),
    .busy      (busy),
    .overrun   (overrun),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: {idx, last, data}
  logic [18:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          hs_cnt   = 0;
  logic        hold_pend = 1'b0;
  logic [19:0] hold_snap;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        n_checks++;
        if ({bus.out_valid, bus.out_data, bus.out_idx, bus.out_last} !== hold_snap) begin
          n_fail++;
          $display("FAIL hold_stable: got %0h expected %0h",
                   {bus.out_valid, bus.out_data, bus.out_idx, bus.out_last}, hold_snap);
        end
      end
      hold_pend = bus.out_valid && !bus.out_ready;
      hold_snap = {bus.out_valid, bus.out_data, bus.out_idx, bus.out_last};
      if (bus.out_valid && bus.out_ready) begin
        logic [18:0] got;
        logic [18:0] want;
        hs_cnt++;
        n_checks++;
        got = {bus.out_idx, bus.out_last, bus.out_data};
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected no output", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            n_fail++;
            $display("FAIL beat: got %0h expected %0h", got, want);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic load(input logic [31:0] a0, a1, a2, a3,
                      input logic [4:0]  e0, e1, e2, e3,
                      input logic [15:0] r0, r1, r2, r3);
    acc_in = {a3, a2, a1, a0};
    exp_in = {e3, e2, e1, e0};
    exp_q.push_back({2'd0, 1'b0, r0});
    exp_q.push_back({2'd1, 1'b0, r1});
    exp_q.push_back({2'd2, 1'b0, r2});
    exp_q.push_back({2'd3, 1'b1, r3});
  endtask

  task automatic start_drain();
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
  endtask

  task automatic wait_idle(output int cyc, output int first_valid);
    cyc = 0;
    first_valid = -1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.out_valid && first_valid < 0) first_valid = cyc;
      if (!busy) return;
    end
    chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_valid_idx(input logic [IDX_W-1:0] idx);
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid && bus.out_idx == idx) begin
        bus.out_ready = 1'b0;
        return;
      end
    end
    chk("wait_valid_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
    end
  endtask

  int cyc;
  int fv;
  int hs0;

  initial begin
    rst = 1'b0;
    done = 1'b0;
    acc_in = '0;
    exp_in = '0;
    bus.out_ready = 1'b1;
    idle_cycles(3);
    chk("rst_valid",   32'(bus.out_valid), 32'd0);
    chk("rst_data",    32'(bus.out_data),  32'd0);
    chk("rst_idx",     32'(bus.out_idx),   32'd0);
    chk("rst_last",    32'(bus.out_last),  32'd0);
    chk("rst_busy",    32'(busy),          32'd0);
    chk("rst_overrun", 32'(overrun),       32'd0);
    rst = 1'b1;
    idle_cycles(2);

    // nominal
    load(32'hFFFF9000, 32'hFFFF9000, 32'hFFFFAC00, 32'hFFFFAC00, 5'd15, 5'd15, 5'd15, 5'd15,
         16'hCF00, 16'hCF00, 16'hCD40, 16'hCD40);
    hs0 = hs_cnt;
    start_drain();
    chk("nom_busy_t0",  32'(busy),          32'd1);
    chk("nom_valid_t0", 32'(bus.out_valid), 32'd0);
    wait_idle(cyc, fv);
    chk("nom_first_valid_cycle", 32'(fv),  32'd1);
    chk("nom_drain_cycles",      32'(cyc), 32'd8);
    chk("nom_handshakes",        32'(hs_cnt - hs0), 32'd4);
    chk("nom_queue_empty",       32'(exp_q.size()), 32'd0);
    idle_cycles(2);

    // backpressure on idx 1
    load(32'hFFFF9000, 32'hFFFF9000, 32'hFFFFAC00, 32'hFFFFAC00, 5'd15, 5'd15, 5'd15, 5'd15,
         16'hCF00, 16'hCF00, 16'hCD40, 16'hCD40);
    start_drain();
    wait_valid_idx(2'd1);
    idle_cycles(3);
    chk("bp_held_data", 32'(bus.out_data), 32'h0000CF00);
    chk("bp_held_idx",  32'(bus.out_idx),  32'd1);
    bus.out_ready = 1'b1;
    wait_idle(cyc, fv);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    idle_cycles(2);

    // range limits
    load(32'h7FFFFFFF, 32'h80000000, 32'h00000001, 32'h00000000, 5'd31, 5'd0, 5'd0, 5'd15,
         16'h7C00, 16'hD400, 16'h0000, 16'h0000);
    start_drain();
    wait_idle(cyc, fv);
    chk("range_queue_empty", 32'(exp_q.size()), 32'd0);
    idle_cycles(2);

    // truncation, signed flush, largest normal exponent
    load(32'h00000FFF, 32'h00000400, 32'hFFFFFFFF, 32'h00000400, 5'd15, 5'd15, 5'd5, 5'd30,
         16'h43FF, 16'h3C00, 16'h8000, 16'h7800);
    start_drain();
    wait_idle(cyc, fv);
    chk("trunc_queue_empty", 32'(exp_q.size()), 32'd0);
    idle_cycles(2);

    // overrun during SEND of idx 2; inputs change after capture
    chk("ovr_before", 32'(overrun), 32'd0);
    load(32'hFFFF9000, 32'hFFFF9000, 32'hFFFFAC00, 32'hFFFFAC00, 5'd15, 5'd15, 5'd15, 5'd15,
         16'hCF00, 16'hCF00, 16'hCD40, 16'hCD40);
    start_drain();
    acc_in = {4{32'h12345678}};
    exp_in = {4{5'd3}};
    wait_valid_idx(2'd2);
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    chk("ovr_set", 32'(overrun), 32'd1);
    idle_cycles(1);
    bus.out_ready = 1'b1;
    wait_idle(cyc, fv);
    idle_cycles(10);
    chk("ovr_sticky",      32'(overrun),       32'd1);
    chk("ovr_no_redrain",  32'(busy),          32'd0);
    chk("ovr_queue_empty", 32'(exp_q.size()),  32'd0);

    // reset mid-drain during SEND of idx 1
    load(32'hFFFF9000, 32'hFFFF9000, 32'hFFFFAC00, 32'hFFFFAC00, 5'd15, 5'd15, 5'd15, 5'd15,
         16'hCF00, 16'hCF00, 16'hCD40, 16'hCD40);
    start_drain();
    wait_valid_idx(2'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid",   32'(bus.out_valid), 32'd0);
    chk("mid_rst_data",    32'(bus.out_data),  32'd0);
    chk("mid_rst_idx",     32'(bus.out_idx),   32'd0);
    chk("mid_rst_last",    32'(bus.out_last),  32'd0);
    chk("mid_rst_busy",    32'(busy),          32'd0);
    chk("mid_rst_overrun", 32'(overrun),       32'd0);
    exp_q.delete();
    idle_cycles(2);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    hs0 = hs_cnt;
    idle_cycles(10);
    chk("post_rst_silent_hs",    32'(hs_cnt - hs0), 32'd0);
    chk("post_rst_silent_valid", 32'(bus.out_valid), 32'd0);
    load(32'h00000FFF, 32'h00000400, 32'hFFFFFFFF, 32'h00000400, 5'd15, 5'd15, 5'd5, 5'd30,
         16'h43FF, 16'h3C00, 16'h8000, 16'h7800);
    start_drain();
    wait_idle(cyc, fv);
    chk("post_rst_drain_hs",   32'(hs_cnt - hs0), 32'd4);
    chk("post_rst_queue_empty", 32'(exp_q.size()), 32'd0);
    idle_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/systolic_drain.md
# systolic_drain

Output-side reader for the FP-INT systolic array. When the array signals `done`, this block captures the N×N per-PE results: a signed fixed-point accumulator plus a 5-bit exponent for each PE. It converts each result to IEEE FP16 and streams the results in PE order over a valid/ready interface. It sits between the systolic array outputs and the activation writeback path.

## Interface
Parameters:
- ACC_WIDTH, 32, accumulator width per PE (two's complement)
- N, 2, array dimension; N*N results per drain
- IDX_W, 2, width of the result index; must be ≥ clog2(N*N)

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- done  input  1  array completion level; a 0→1 transition starts a drain
- acc_in  input  N*N*ACC_WIDTH  flattened accumulators; PE k = i*N+j at bits [k*ACC_WIDTH +: ACC_WIDTH]
- exp_in  input  N*N*5  flattened exponents; PE k at bits [k*5 +: 5]
- out_valid  output  1  out_data/out_idx/out_last valid
- out_ready  input  1  downstream accepts when high with out_valid
- out_data  output  16  FP16 result
- out_idx  output  IDX_W  PE index k of out_data
- out_last  output  1  high with the final element (k = N*N-1)
- busy  output  1  high from capture until the last element is accepted
- overrun  output  1  sticky; a done rise was ignored while busy

## Operation
- Value encoding: value = signed(acc) × 2^(exp − 25), i.e. bias 15 with 10 fraction bits.
- Done edge: `done_d` registers `done`. A rise is `done & ~done_d`.
- FSM states: IDLE, CONVERT, SEND.
  - IDLE: on a rise, register all of acc_in and exp_in, set k=0 and busy=1, and go to CONVERT.
  - CONVERT: convert element k and register out_data, out_idx=k, out_last=(k==N*N-1) and out_valid=1. Go to SEND.
  - SEND: hold all outputs stable while out_ready=0. On out_valid & out_ready:
    - if out_last, clear out_valid and busy and go to IDLE;
    - otherwise clear out_valid, set k=k+1 and go to CONVERT.
- Overrun: a done rise while busy is ignored (captured data is unchanged) and sets overrun. overrun is cleared only by reset.
- Conversion of one element:
  - sign s = acc[ACC_WIDTH-1].
  - mag = |acc| as an ACC_WIDTH-bit unsigned value. The most-negative acc gives mag = 2^(ACC_WIDTH-1), with no wrap.
  - If mag = 0, the result is 0x0000 (positive zero, regardless of sign or exp).
  - p = bit position of the leading one of mag.
  - E = p + exp − 10, computed as a signed value at least 8 bits wide.
  - Mantissa = the 10 bits immediately below the leading one. Zero-pad on the right if p < 10. Truncate toward zero; no rounding.
  - If E ≥ 31, the result is {s, 5'h1F, 10'h0} (±inf).
  - If E ≤ 0, the result is {s, 15'h0} (flush to signed zero; no denormals).
  - Otherwise the result is {s, E[4:0], mantissa}.
- Captured inputs are held until the drain completes. acc_in and exp_in may change freely after capture.

## Timing
- Reset values, applied asynchronously: out_valid=0, out_data=16'h0, out_idx=0, out_last=0, busy=0, overrun=0, done_d=0. The FSM goes to IDLE and k=0.
- Reset mid-drain aborts the drain and discards captured data. No further out_valid follows until a new done rise.
- Latency: edge T0 samples the done rise and captures. out_valid is high after edge T1.
- Throughput: one element per 2 cycles with out_ready held high, because CONVERT is a one-cycle bubble.
- A full drain with out_ready=1 takes 2·N*N cycles from capture to busy falling.
- A done that stays high does not retrigger. Another drain needs done to fall and rise again.
- A done rise on the same edge that the last element is accepted counts as an overrun and is ignored, because busy is still 1 at that edge.
- out_valid never drops without a handshake, and out_data is stable while out_valid & ~out_ready.

## Test plan
- Nominal (N=2), out_ready=1:
  - Stimulus: acc = {FFFF9000, FFFF9000, FFFFAC00, FFFFAC00}, all exp = 15, then a done rise.
  - Response: out_data = CF00, CF00, CD40, CD40 with out_idx 0..3. out_last is set only with idx 3. out_valid first goes high after the 2nd edge. busy falls after the 4th handshake.
- Backpressure: in the nominal stream, hold out_ready=0 for 3 cycles on idx 1 → idx 1 with CF00 is held stable, no element is skipped, and ordering is preserved.
- Range limits:
  - acc=7FFFFFFF, exp=31 → 7C00.
  - acc=80000000, exp=0 → D400.
  - acc=00000001, exp=0 → 0000.
  - acc=0, exp=15 → 0000.
- Truncation: acc=00000FFF, exp=15 → 43FF. acc=00000400, exp=15 → 3C00.
- Overrun: pulse done again during SEND of idx 2 → overrun=1 and stays 1. The remaining output stream is unchanged. No second drain starts afterwards.
- Reset mid-drain: assert rst during SEND of idx 1 → all outputs go to their reset values immediately. After release, nothing is output until a new done rise, and the new drain starts at idx 0.
